reg_file_operand: RTL and testbench
===================================

// Module: reg_file_operand
// PURPOSE
//  LC-3 register file and operand-select stage directly upstream of the ALU.
//  Holds R0-R7, selects the SR1 operand for ALU Input_A, and selects SR2 or sext(imm5) for ALU Input_B.
//  Writes back the datapath bus into the register file.
//  Also owns the NZP condition-code register and the BEN branch-enable flop consumed by the FSM.
// PARAMETERS
//  DATA_W    16  datapath / register width
//  NUM_REGS   8  number of general-purpose registers (register index = 3 bits)
//  IMM_W      5  width of the immediate field IR[IMM_W-1:0], sign-extended to DATA_W
// PORTS
//  Clk         in   1       rising-edge clock
//  Reset_n     in   1       synchronous reset, active low
//  Bus         in   DATA_W  datapath bus: register write data and CC source
//  IR          in   16      current instruction register
//  LD_REG      in   1       write Bus into register selected by DR
//  LD_CC       in   1       update NZP from Bus
//  LD_BEN      in   1       update BEN from IR[11:9] and NZP
//  DRMUX       in   1       0: DR=IR[11:9]  1: DR=3'b111 (R7)
//  SR1MUX      in   1       0: SR1=IR[11:9] 1: SR1=IR[8:6]
//  SR2MUX      in   1       0: Input_B=R[IR[2:0]]  1: Input_B=sext(IR[IMM_W-1:0])
//  SR1_out     out  DATA_W  selected SR1 register value (to ALU Input_A, ADDR1MUX)
//  SR2MUX_out  out  DATA_W  selected second operand (to ALU Input_B)
//  NZP         out  3       condition codes {N,Z,P}
//  BEN         out  1       registered branch-enable
// BEHAVIOUR
//  Reset (Reset_n=0 at rising Clk): R0-R7 <= 0, NZP <= 3'b000, BEN <= 0.
//   - Reset has priority over all LD_* signals.
//   - SR1_out/SR2MUX_out are combinational, so they read 0 (or sext imm) one cycle after reset.
//  Register write:
//   - On a rising Clk with LD_REG=1, R[DR] <= Bus.
//   - LD_REG=0: no register changes.
//  Reads:
//   - SR1_out and SR2MUX_out are combinational from the stored registers. There is no write bypass.
//   - A register written at edge k is visible on the outputs only after edge k.
//   - Read-during-write of the same register in one cycle returns the OLD value until the edge.
//  sext: SR2MUX_out = {{(DATA_W-IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]} when SR2MUX=1.
//   - Example: IR[4:0]=5'b10000 -> 16'hFFF0.
//  NZP update (LD_CC=1 at edge):
//   - N=Bus[DATA_W-1]; Z=(Bus==0); P=~N&~Z.
//   - Exactly one bit is set after any load. Holds otherwise.
//  BEN update (LD_BEN=1 at edge): BEN <= (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), using the NZP value held BEFORE the edge.
//  Simultaneous events:
//   - LD_CC+LD_BEN in the same cycle: BEN uses the old NZP; NZP updates in parallel.
//   - LD_REG+LD_CC: both take effect; CC is computed from Bus, not from the register.
//  Latency: 0 cycles combinational read; 1 edge for write, CC and BEN.
//  No internal state machine; sequencing is owned by the control FSM.
//  Mid-operation reset discards any pending load in that cycle.
// TESTING
//  1. Reset_n=0 for 1 edge with LD_REG=1, Bus=16'h1234 -> all regs 0, NZP=000, BEN=0. Write suppressed.
//  2. DRMUX=0, IR[11:9]=3, Bus=16'h00A5, LD_REG=1 for 1 edge.
//     Then SR1MUX=1, IR[8:6]=3 -> SR1_out=16'h00A5.
//     Same-cycle read before the edge shows 16'h0000.
//  3. R2=16'h0007, IR[2:0]=2: SR2MUX=0 -> 16'h0007.
//     SR2MUX=1, IR[4:0]=5'b11111 -> 16'hFFFF.
//  4. LD_CC with Bus=16'h8000 -> NZP=100. Bus=0 -> 010. Bus=16'h0001 -> 001.
//  5. NZP=010, IR[11:9]=3'b010, LD_CC(Bus=16'h0001)+LD_BEN in the same cycle -> BEN=1, NZP=001.
//     Next LD_BEN with the same IR -> BEN=0.
//  6. DRMUX=1, LD_REG, Bus=16'h3001 -> R7=16'h3001. Register at IR[11:9] unchanged.

Source files
------------

// File: rtl/reg_file_operand.sv
// reg_file_operand: LC-3 register file and operand-select stage feeding the ALU.
//
// Holds R0..R(NUM_REGS-1), presents the SR1 operand on SR1_out (ALU Input_A) and
// either SR2 or sext(IR[IMM_W-1:0]) on SR2MUX_out (ALU Input_B). Writes the
// datapath bus back into the register file. Also owns the NZP condition codes
// and the registered BEN branch-enable flag consumed by the control FSM.
//
// Ports:
//   Clk         rising-edge clock
//   Reset_n     synchronous reset, active low; wins over every load
//   Bus         datapath bus: register write data and condition-code source
//   IR          current instruction register
//   LD_REG      write Bus into R[DR] at the edge
//   LD_CC       update NZP from Bus at the edge
//   LD_BEN      update BEN from IR[11:9] and the pre-edge NZP
//   DRMUX       0: DR = IR[11:9]   1: DR = R7
//   SR1MUX      0: SR1 = IR[11:9]  1: SR1 = IR[8:6]
//   SR2MUX      0: Input_B = R[IR[2:0]]  1: Input_B = sext(IR[IMM_W-1:0])
//   SR1_out     selected SR1 register value
//   SR2MUX_out  selected second ALU operand
//   NZP         condition codes {N, Z, P}
//   BEN         registered branch enable
//
// Reads are purely combinational from stored state with no write bypass, so a
// register written at an edge is only visible after that edge.

module reg_file_operand #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IMM_W    = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] Bus,
  input  logic [15:0]       IR,
  input  logic              LD_REG,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  input  logic              SR2MUX,
  output logic [DATA_W-1:0] SR1_out,
  output logic [DATA_W-1:0] SR2MUX_out,
  output logic [2:0]        NZP,
  output logic              BEN
);

  // Register specifiers are fixed 3-bit fields of the LC-3 instruction word.
  localparam int unsigned RegIdxW = 3;
  localparam logic [RegIdxW-1:0] LinkReg = 3'b111;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [2:0]        nzp_q, nzp_d;
  logic              ben_q, ben_d;

  // ---------------------------------------------------------------------------
  // Register specifier decode
  // ---------------------------------------------------------------------------
  logic [RegIdxW-1:0] dr_idx;
  logic [RegIdxW-1:0] sr1_idx;
  logic [RegIdxW-1:0] sr2_idx;

  always_comb begin
    dr_idx  = DRMUX  ? LinkReg : IR[11:9];
    sr1_idx = SR1MUX ? IR[8:6] : IR[11:9];
    sr2_idx = IR[2:0];
  end

  // IR[15:12] (opcode) and IR[5] (imm/reg mode bit) are decoded by the FSM.
  logic unused_ir;
  assign unused_ir = ^{IR[15:12], IR[5]};

  // ---------------------------------------------------------------------------
  // Register file write
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (LD_REG) begin
      regs_d[dr_idx] = Bus;
    end
  end

  // ---------------------------------------------------------------------------
  // Condition codes
  // ---------------------------------------------------------------------------
  logic bus_neg;
  logic bus_zero;

  always_comb begin
    bus_neg  = Bus[DATA_W-1];
    bus_zero = (Bus == '0);
    nzp_d    = nzp_q;
    if (LD_CC) begin
      nzp_d = {bus_neg, bus_zero, ~bus_neg & ~bus_zero};
    end
  end

  // ---------------------------------------------------------------------------
  // Branch enable: always built from the NZP held before the edge, so a
  // same-cycle LD_CC never feeds the new codes into BEN.
  // ---------------------------------------------------------------------------
  always_comb begin
    ben_d = ben_q;
    if (LD_BEN) begin
      ben_d = (IR[11] & nzp_q[2]) | (IR[10] & nzp_q[1]) | (IR[9] & nzp_q[0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state; synchronous reset discards any load in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      nzp_q <= 3'b000;
      ben_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      nzp_q <= nzp_d;
      ben_q <= ben_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand select (combinational, no bypass)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] imm_sext;

  always_comb begin
    imm_sext   = {{(DATA_W-IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]};
    SR1_out    = regs_q[sr1_idx];
    SR2MUX_out = SR2MUX ? imm_sext : regs_q[sr2_idx];
  end

  assign NZP = nzp_q;
  assign BEN = ben_q;

endmodule

// File: tb/tb_reg_file_operand.sv
module tb_reg_file_operand;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] Bus;
  logic [15:0] IR;
  logic        LD_REG, LD_CC, LD_BEN, DRMUX, SR1MUX, SR2MUX;
  logic [15:0] SR1_out, SR2MUX_out;
  logic [2:0]  NZP;
  logic        BEN;

  reg_file_operand #(
    .DATA_W  (16),
    .NUM_REGS(8),
    .IMM_W   (5)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Bus       (Bus),
    .IR        (IR),
    .LD_REG    (LD_REG),
    .LD_CC     (LD_CC),
    .LD_BEN    (LD_BEN),
    .DRMUX     (DRMUX),
    .SR1MUX    (SR1MUX),
    .SR2MUX    (SR2MUX),
    .SR1_out   (SR1_out),
    .SR2MUX_out(SR2MUX_out),
    .NZP       (NZP),
    .BEN       (BEN)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: an array of registers plus the last condition and flag.
  // ---------------------------------------------------------------------------
  logic [15:0] m_reg [8];
  logic [2:0]  m_nzp;
  logic        m_ben;
  logic        chk_en = 1'b0;

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v == 16'd0) return 3'b010;
    else if (v >= 16'h8000) return 3'b100;
    else return 3'b001;
  endfunction

  function automatic logic taken(input logic [15:0] ir, input logic [2:0] cc);
    return (ir[11] && cc == 3'b100) || (ir[10] && cc == 3'b010) || (ir[9] && cc == 3'b001);
  endfunction

  function automatic logic [15:0] exp_a();
    return SR1MUX ? m_reg[IR[8:6]] : m_reg[IR[11:9]];
  endfunction

  function automatic logic [15:0] exp_b();
    int v;
    if (!SR2MUX) return m_reg[IR[2:0]];
    v = int'(IR[4:0]);
    if (v >= 16) v = v - 32;
    return v[15:0];
  endfunction

  always @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= 16'd0;
      m_nzp  <= 3'b000;
      m_ben  <= 1'b0;
      chk_en <= 1'b1;
    end else begin
      if (LD_REG) m_reg[DRMUX ? 3'd7 : IR[11:9]] <= Bus;
      if (LD_CC)  m_nzp <= cc_of(Bus);
      if (LD_BEN) m_ben <= taken(IR, m_nzp);
    end
  end

  // Compare process: inputs change at negedge, outputs checked 2 time units later.
  always @(negedge Clk) begin
    #2;
    if (chk_en) begin
      check("model_sr1", SR1_out, exp_a());
      check("model_sr2mux", SR2MUX_out, exp_b());
      check("model_nzp", {13'd0, NZP}, {13'd0, m_nzp});
      check("model_ben", {15'd0, BEN}, {15'd0, m_ben});
    end
  end

  // One cycle of stimulus: drive at negedge, return 3 units later (before the edge).
  task automatic cyc(input logic rn, input logic lr, input logic lc, input logic lb,
                     input logic dm, input logic s1, input logic s2,
                     input logic [15:0] ir, input logic [15:0] bus);
    @(negedge Clk);
    Reset_n = rn; LD_REG = lr; LD_CC = lc; LD_BEN = lb;
    DRMUX = dm; SR1MUX = s1; SR2MUX = s2; IR = ir; Bus = bus;
    #3;
  endtask

  function automatic logic [15:0] mk_ir(input logic [2:0] f119, input logic [2:0] f86,
                                        input logic [5:0] lo);
    return {4'b0001, f119, f86, lo};
  endfunction

  initial begin
    Reset_n = 1'b0; LD_REG = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0;
    DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; IR = 16'd0; Bus = 16'd0;

    // 1. Reset with a pending write: write suppressed, everything zero.
    cyc(0, 1, 1, 1, 0, 0, 0, mk_ir(3'd0, 3'd0, 6'd0), 16'h1234);
    cyc(0, 1, 1, 1, 0, 0, 0, mk_ir(3'd0, 3'd0, 6'd0), 16'h1234);
    for (int r = 0; r < 8; r++) begin
      cyc(1, 0, 0, 0, 0, 1, 0, mk_ir(3'd0, 3'(r), 6'd0), 16'h0000);
      check("reset_reg", SR1_out, 16'h0000);
    end
    check("reset_nzp", {13'd0, NZP}, 16'd0);
    check("reset_ben", {15'd0, BEN}, 16'd0);

    // 2. Write R3, no bypass during the writing cycle.
    cyc(1, 1, 0, 0, 0, 1, 0, mk_ir(3'd3, 3'd3, 6'd0), 16'h00A5);
    check("no_bypass", SR1_out, 16'h0000);
    cyc(1, 0, 0, 0, 0, 1, 0, mk_ir(3'd3, 3'd3, 6'd0), 16'h0000);
    check("write_r3", SR1_out, 16'h00A5);

    // 3. SR2 register path and immediate sign extension.
    cyc(1, 1, 0, 0, 0, 0, 0, mk_ir(3'd2, 3'd0, 6'd0), 16'h0007);
    cyc(1, 0, 0, 0, 0, 0, 0, mk_ir(3'd0, 3'd0, 6'b000010), 16'h0000);
    check("sr2_reg", SR2MUX_out, 16'h0007);
    cyc(1, 0, 0, 0, 0, 0, 1, mk_ir(3'd0, 3'd0, 6'b011111), 16'h0000);
    check("sext_m1", SR2MUX_out, 16'hFFFF);
    cyc(1, 0, 0, 0, 0, 0, 1, mk_ir(3'd0, 3'd0, 6'b010000), 16'h0000);
    check("sext_m16", SR2MUX_out, 16'hFFF0);
    cyc(1, 0, 0, 0, 0, 0, 1, mk_ir(3'd0, 3'd0, 6'b001111), 16'h0000);
    check("sext_p15", SR2MUX_out, 16'h000F);

    // 4. Condition codes.
    cyc(1, 0, 1, 0, 0, 0, 0, mk_ir(3'd0, 3'd0, 6'd0), 16'h8000);
    cyc(1, 0, 1, 0, 0, 0, 0, mk_ir(3'd0, 3'd0, 6'd0), 16'h0000);
    check("cc_neg", {13'd0, NZP}, 16'b100);
    cyc(1, 0, 1, 0, 0, 0, 0, mk_ir(3'd0, 3'd0, 6'd0), 16'h0001);
    check("cc_zero", {13'd0, NZP}, 16'b010);
    cyc(1, 0, 0, 0, 0, 0, 0, mk_ir(3'd0, 3'd0, 6'd0), 16'hFFFF);
    check("cc_pos", {13'd0, NZP}, 16'b001);

    // 5. BEN uses the pre-edge NZP when LD_CC and LD_BEN coincide.
    cyc(1, 0, 1, 0, 0, 0, 0, mk_ir(3'd0, 3'd0, 6'd0), 16'h0000);
    cyc(1, 0, 1, 1, 0, 0, 0, mk_ir(3'b010, 3'd0, 6'd0), 16'h0001);
    check("ben_pre_nzp", {13'd0, NZP}, 16'b010);
    cyc(1, 0, 0, 1, 0, 0, 0, mk_ir(3'b010, 3'd0, 6'd0), 16'h0000);
    check("ben_set", {15'd0, BEN}, 16'd1);
    check("ben_new_nzp", {13'd0, NZP}, 16'b001);
    cyc(1, 0, 0, 0, 0, 0, 0, mk_ir(3'b010, 3'd0, 6'd0), 16'h0000);
    check("ben_clear", {15'd0, BEN}, 16'd0);

    // 6. DRMUX=1 targets R7, leaves R[IR[11:9]] untouched.
    cyc(1, 1, 0, 0, 1, 0, 0, mk_ir(3'd3, 3'd0, 6'd0), 16'h3001);
    cyc(1, 0, 0, 0, 0, 0, 0, mk_ir(3'd7, 3'd0, 6'd0), 16'h0000);
    check("r7_write", SR1_out, 16'h3001);
    cyc(1, 0, 0, 0, 0, 0, 0, mk_ir(3'd3, 3'd0, 6'd0), 16'h0000);
    check("r3_kept", SR1_out, 16'h00A5);

    // Randomized traffic with occasional resets, checked by the compare process.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] rbus;
      rbus = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rbus = 16'h0000;
      cyc(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 16'($urandom), rbus);
    end

    @(negedge Clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
